// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 slave transaction engine.
package spi_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  // Command LSB value that selects a read transaction.
  localparam logic RW_READ = 1'b1;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    GET_CMD      = 4'd1,
    DECODE       = 4'd2,
    READ_WAIT    = 4'd3,
    READ_LOAD    = 4'd4,
    READ_SHIFT   = 4'd5,
    WRITE_GET    = 4'd6,
    WRITE_COMMIT = 4'd7,
    DONE         = 4'd8
  } state_t;

endpackage

// File: rtl/spi_shiftreg.sv
// Left-shifting register: parallel load, serial-in at LSB, plain shift, MSB out.
module spi_shiftreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_in_en,
  input  logic              serial_in,
  input  logic              shift_en,
  output logic              serial_out,
  output logic [DATA_W-1:0] par_out
);

  logic [DATA_W-1:0] q;

  // Load has priority over capture, capture over a plain shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_data;
    end else if (shift_in_en) begin
      q <= {q[DATA_W-2:0], serial_in};
    end else if (shift_en) begin
      q <= {q[DATA_W-2:0], 1'b0};
    end
  end

  assign serial_out = q[DATA_W-1];
  assign par_out    = q;

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI mode-0 slave: command byte {addr, rw}, then one write or read data byte.
// Handshake: there is no valid/ready pair here; mem_we is a single-cycle
// strobe qualifying mem_addr/mem_wdata, and mem_rdata is taken exactly one
// clk after mem_addr has been updated.
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_cond,
  input  logic              sclk_pos,
  input  logic              sclk_neg,
  input  logic              mosi_cond,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              miso,
  output logic              miso_oe,
  output logic [3:0]        state_dbg
);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              seen_q, seen_d;
  logic              sh_load, sh_shift_in, sh_shift, sh_msb;
  logic [DATA_W-1:0] sh_load_data, sh_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              we_d, miso_d, oe_d;
  logic              last_bit;

  assign last_bit  = (cnt_q == 3'd7);
  assign state_dbg = state_q;

  spi_shiftreg #(.DATA_W(DATA_W)) u_shreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (sh_load),
    .load_data  (sh_load_data),
    .shift_in_en(sh_shift_in),
    .serial_in  (mosi_cond),
    .shift_en   (sh_shift),
    .serial_out (sh_msb),
    .par_out    (sh_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; CS high anywhere outside IDLE aborts the frame.
  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && cs_cond) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:         if (!cs_cond) state_d = GET_CMD;
        GET_CMD:      if (sclk_pos && last_bit) state_d = DECODE;
        DECODE:       state_d = (sh_q[0] == RW_READ) ? READ_WAIT : WRITE_GET;
        READ_WAIT:    state_d = READ_LOAD;
        READ_LOAD:    state_d = READ_SHIFT;
        READ_SHIFT:   if (sclk_pos && last_bit) state_d = DONE;
        WRITE_GET:    if (sclk_pos && last_bit) state_d = WRITE_COMMIT;
        WRITE_COMMIT: state_d = DONE;
        DONE:         state_d = DONE;
        default:      state_d = IDLE;
      endcase
    end
  end

  // Output and datapath decode; nothing but the abort happens while CS is high.
  always_comb begin
    cnt_d        = cnt_q;
    seen_d       = seen_q;
    sh_load      = 1'b0;
    sh_load_data = '0;
    sh_shift_in  = 1'b0;
    sh_shift     = 1'b0;
    addr_d       = mem_addr;
    wdata_d      = mem_wdata;
    we_d         = 1'b0;
    oe_d         = 1'b0;
    miso_d       = 1'b0;
    if (!cs_cond) begin
      case (state_q)
        IDLE: begin
          cnt_d   = 3'd0;
          seen_d  = 1'b0;
          sh_load = 1'b1;
        end
        GET_CMD, WRITE_GET: begin
          if (sclk_pos) begin
            sh_shift_in = 1'b1;
            cnt_d       = cnt_q + 3'd1;
          end
        end
        DECODE: begin
          addr_d = sh_q[ADDR_W:1];
          cnt_d  = 3'd0;
        end
        READ_LOAD: begin
          sh_load      = 1'b1;
          sh_load_data = mem_rdata;
          oe_d         = 1'b1;
          seen_d       = 1'b0;
          cnt_d        = 3'd0;
        end
        READ_SHIFT: begin
          oe_d   = 1'b1;
          miso_d = sh_msb;
          // The falling edge trailing the command byte arrives before any
          // data-phase rising edge and must not consume the MSB.
          if (sclk_pos) begin
            cnt_d  = cnt_q + 3'd1;
            seen_d = 1'b1;
          end else if (sclk_neg && seen_q) begin
            sh_shift = 1'b1;
          end
        end
        WRITE_COMMIT: begin
          wdata_d = sh_q;
          we_d    = 1'b1;
        end
        DONE: begin
          oe_d   = miso_oe;
          miso_d = miso_oe & sh_msb;
        end
        default: ;
      endcase
    end
  end

  // Output, counter and phase-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 3'd0;
      seen_q    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_we    <= we_d;
      miso      <= miso_d;
      miso_oe   <= oe_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Bench for spi_slave_fsm: directed frames plus random read/write frames
// checked against a reference memory image and an expected-write queue.
module tb_spi_slave_fsm;
  import spi_pkg::*;

  localparam int AW = 7;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs_cond;
  logic          sclk_pos;
  logic          sclk_neg;
  logic          mosi_cond;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          miso;
  logic          miso_oe;
  logic [3:0]    state_dbg;

  spi_slave_fsm #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_cond  (cs_cond),
    .sclk_pos (sclk_pos),
    .sclk_neg (sclk_neg),
    .mosi_cond(mosi_cond),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Synchronous-read memory attached to the DUT.
  logic [DW-1:0] mem [128];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] = mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Reference model: expected memory image and expected write stream.
  logic [DW-1:0]      ref_mem [128];
  logic [AW+DW-1:0]   exp_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   we_count = 0;
  logic oe_seen  = 1'b0;
  logic noise_mode = 1'b0;
  logic noise_bad  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin : sb
    logic [AW+DW-1:0] e;
    if (rst_n && mem_we) begin
      we_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("we_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
        chk("we_data", 32'(mem_wdata), 32'(e[DW-1:0]));
      end
    end
    if (miso_oe) oe_seen = 1'b1;
    if (noise_mode && state_dbg != IDLE) noise_bad = 1'b1;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCLK cycle per bit, half period 4 clk; MISO sampled at the rising edge.
  task automatic send_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi_cond = tx[7-i];
      tick(3);
      sclk_pos = 1'b1;
      rx = {rx[6:0], miso};
      tick(1);
      sclk_pos = 1'b0;
      tick(3);
      sclk_neg = 1'b1;
      tick(1);
      sclk_neg = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_cond = 1'b0;
    oe_seen = 1'b0;
    tick(2);
  endtask

  task automatic cs_high();
    tick(3);
    cs_cond = 1'b1;
    tick(3);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic [7:0] rx;
    exp_q.push_back({addr, data});
    ref_mem[addr] = data;
    cs_low();
    send_bits({addr, 1'b0}, 8, rx);
    send_bits(data, 8, rx);
    cs_high();
  endtask

  task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] rx);
    logic [7:0] dummy;
    cs_low();
    send_bits({addr, 1'b1}, 8, dummy);
    send_bits(8'($urandom_range(0, 255)), 8, rx);
    cs_high();
  endtask

  logic [7:0] rx;
  int         wc;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cs_cond = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0; mosi_cond = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem[i]     = 8'($urandom_range(0, 255));
      ref_mem[i] = mem[i];
    end
    tick(3);
    chk("rst_addr",  32'(mem_addr),  32'(0));
    chk("rst_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_we",    32'(mem_we),    32'(0));
    chk("rst_miso",  32'(miso),      32'(0));
    chk("rst_oe",    32'(miso_oe),   32'(0));
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;
    tick(3);

    // Write frame: cmd 0x24, data 0xA5.
    wc = we_count;
    do_write(7'h12, 8'hA5);
    chk("wr_we_count", 32'(we_count - wc), 32'(1));
    chk("wr_addr",     32'(mem_addr),      32'(7'h12));
    chk("wr_wdata",    32'(mem_wdata),     32'(8'hA5));
    chk("wr_oe_quiet", 32'(oe_seen),       32'(0));

    // Read frame: cmd 0x0B, memory holds 0x3C.
    mem[5] = 8'h3C; ref_mem[5] = 8'h3C;
    cs_low();
    send_bits(8'h0B, 8, rx);
    send_bits(8'h00, 8, rx);
    chk("rd_bits",  32'(rx),       32'(8'h3C));
    chk("rd_addr",  32'(mem_addr), 32'(7'h05));
    tick(2);
    chk("rd_oe_held", 32'(miso_oe), 32'(1));
    cs_cond = 1'b1;
    tick(1);
    chk("rd_oe_drop", 32'(miso_oe),   32'(0));
    chk("rd_idle",    32'(state_dbg), 32'(IDLE));
    tick(3);

    // Abort a write after 5 data bits, then a full write.
    wc = we_count;
    cs_low();
    send_bits(8'h24, 8, rx);
    send_bits(8'hFF, 5, rx);
    cs_cond = 1'b1;
    tick(1);
    chk("abort_state", 32'(state_dbg), 32'(IDLE));
    tick(6);
    chk("abort_no_we", 32'(we_count - wc), 32'(0));
    chk("abort_addr",  32'(mem_addr),      32'(7'h12));
    do_write(7'h12, 8'h5A);
    chk("abort_rewrite", 32'(mem_wdata), 32'(8'h5A));
    chk("abort_mem",     32'(mem[7'h12]), 32'(ref_mem[7'h12]));

    // Overrun: extra byte after a complete write.
    wc = we_count;
    exp_q.push_back({7'h01, 8'hFF});
    ref_mem[1] = 8'hFF;
    cs_low();
    send_bits(8'h02, 8, rx);
    send_bits(8'hFF, 8, rx);
    send_bits(8'h00, 8, rx);
    cs_high();
    chk("ovr_we_count", 32'(we_count - wc), 32'(1));
    chk("ovr_wdata",    32'(mem_wdata),     32'(8'hFF));

    // Idle noise with CS high.
    wc = we_count;
    oe_seen = 1'b0;
    noise_mode = 1'b1;
    send_bits(8'($urandom_range(0, 255)), 8, rx);
    send_bits(8'($urandom_range(0, 255)), 8, rx);
    noise_mode = 1'b0;
    chk("noise_state", 32'(noise_bad),      32'(0));
    chk("noise_we",    32'(we_count - wc),  32'(0));
    chk("noise_oe",    32'(oe_seen),        32'(0));

    // Random frames against the reference memory image.
    for (int k = 0; k < 20; k++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = 7'($urandom_range(0, 127));
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        do_read(a, rx);
        chk("rand_rd_data", 32'(rx),       32'(ref_mem[a]));
        chk("rand_rd_addr", 32'(mem_addr), 32'(a));
      end else begin
        wc = we_count;
        do_write(a, d);
        chk("rand_wr_count", 32'(we_count - wc), 32'(1));
        chk("rand_wr_data",  32'(mem_wdata),     32'(d));
        chk("rand_wr_oe",    32'(oe_seen),       32'(0));
      end
    end

    // Asynchronous reset in the middle of a write data byte.
    do_write(7'h33, 8'h77);
    wc = we_count;
    cs_low();
    send_bits(8'h24, 8, rx);
    send_bits(8'hC3, 4, rx);
    chk("pre_rst_addr", 32'(mem_addr), 32'(7'h12));
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_addr",  32'(mem_addr),  32'(0));
    chk("arst_wdata", 32'(mem_wdata), 32'(0));
    chk("arst_we",    32'(mem_we),    32'(0));
    chk("arst_miso",  32'(miso),      32'(0));
    chk("arst_oe",    32'(miso_oe),   32'(0));
    chk("arst_state", 32'(state_dbg), 32'(IDLE));
    cs_cond = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("arst_no_we",  32'(we_count - wc),  32'(0));
    chk("exp_q_empty", 32'(exp_q.size()),   32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_fsm.md
Name: spi_slave_fsm

Overview:
- SPI mode-0 slave transaction engine. It sits directly downstream of the three input-conditioner instances: CS, SCLK and MOSI.
- Consumes the conditioned chip select, the SCLK edge pulses and the conditioned MOSI.
- Decodes a 1-byte command (7-bit address + R/W bit), then either captures a write byte or shifts a read byte out on MISO.
- Drives a simple synchronous-read data memory.

Parameters:
- ADDR_W, 7, memory address width; command byte is ADDR_W+1 bits.
- DATA_W, 8, data word width and shift register width.

Ports:
- clk  in  1  system clock; the same domain as the conditioners.
- rst_n  in  1  asynchronous, active-low reset.
- cs_cond  in  1  conditioned chip select, active low.
- sclk_pos  in  1  one-clk pulse at each SCLK rising edge.
- sclk_neg  in  1  one-clk pulse at each SCLK falling edge.
- mosi_cond  in  1  conditioned MOSI level.
- mem_rdata  in  DATA_W  memory read data, valid 1 clk after mem_addr changes.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered write data.
- mem_we  out  1  one-clk write strobe.
- miso  out  1  serial data out, MSB first.
- miso_oe  out  1  MISO tri-state enable; high only during read-data phase.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; bit counter=0; shift register=0; miso=0; miso_oe=0; mem_we=0; mem_addr=0; mem_wdata=0.
- All outputs are registered.
- Shift register: DATA_W bits; shifts left; serial-in at LSB; serial-out is the MSB.
- Bit counter: 3 bits; counts sclk_pos events within a byte; wraps 7->0 at the byte boundary.
- States and transitions:
  - IDLE: on cs_cond=0 -> GET_CMD; clear counter and shift register.
  - GET_CMD: on each sclk_pos, shift in mosi_cond. After the 8th sclk_pos -> DECODE. The shift register then holds {A[6:0], RW}.
  - DECODE (1 clk): mem_addr <= shreg[7:1]. RW=1 -> READ_WAIT; RW=0 -> WRITE_GET, counter cleared.
  - READ_WAIT (1 clk): memory latency slot.
  - READ_LOAD (1 clk): shreg <= mem_rdata; miso_oe <= 1 -> READ_SHIFT.
  - READ_SHIFT: miso follows shreg MSB.
    - Shift left on sclk_neg only if at least one sclk_pos has occurred since READ_LOAD. The falling edge that immediately follows the command byte must not shift.
    - Count sclk_pos; after the 8th -> DONE.
  - WRITE_GET: shift in mosi_cond on each sclk_pos; after the 8th -> WRITE_COMMIT.
  - WRITE_COMMIT (1 clk): mem_wdata <= shreg; mem_we=1 for exactly this one cycle -> DONE.
  - DONE: ignore all SCLK edges; miso_oe held; on cs_cond=1 -> IDLE.
- CS deasserted (cs_cond=1) in any state other than IDLE:
  - Next clk: state=IDLE and miso_oe=0.
  - A partially received write never produces mem_we.
  - An aborted frame never alters mem_addr beyond what DECODE already set.
- Edge pulses in IDLE are ignored. Edge pulses during the 1-clk states (DECODE, READ_WAIT, READ_LOAD, WRITE_COMMIT) are illegal timing. Timing constraint: SCLK half-period ≥ 4 clk after conditioning.
- Simultaneous sclk_pos and sclk_neg (should not happen): sclk_pos is processed, sclk_neg is dropped.
- One transaction per CS assertion. Further bytes after DONE are discarded.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum: IDLE, GET_CMD, DECODE, READ_WAIT, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_COMMIT, DONE;
  - ADDR_W/DATA_W defaults;
  - RW_READ=1'b1.
- One sub-module: spi_shiftreg (DATA_W-wide; parallel load; serial-in on shift_in_en; shift on shift_en; MSB serial out; parallel out). The FSM, counter and output registers stay in spi_slave_fsm.

Test Plan:
- Reset: assert rst_n=0 mid-WRITE_GET after 4 data bits -> all outputs 0 immediately with no clk edge; state IDLE; no mem_we after release.
- Write frame: CS low; send command 0x24 (addr 0x12, RW=0), then data 0xA5 -> exactly one mem_we pulse with mem_addr=0x12, mem_wdata=0xA5; miso_oe stays 0 throughout.
- Read frame: send command 0x0B (addr 0x05, RW=1); memory returns 0x3C -> mem_addr=0x05. Levels sampled at SCLK rising edges 9-16 are 0,0,1,1,1,1,0,0. miso_oe=1 from READ_LOAD until 1 clk after CS high.
- Abort: after command 0x24 and 5 data bits, raise CS -> no mem_we ever; state IDLE next clk. The following full write to 0x12 with 0x5A commits 0x5A.
- Overrun: after a complete write of 0xFF to 0x01, clock 8 more bits while CS low -> no second mem_we; mem_wdata remains 0xFF.
- Idle noise: toggle SCLK/MOSI with CS high for 16 edges -> no state change; mem_we=0; miso_oe=0.
